// File: rtl/branch_target_buffer.sv
// Branch target buffer: a direct-mapped table that predicts the next fetch PC.
//
// Each entry holds a valid bit, a tag, a 32-bit target and a 2-bit saturating
// counter (00 SNT, 01 WNT, 10 WT, 11 ST). The index is pc[IDX_W:1] and the tag
// is pc[31:IDX_W+1]. pc[0] is not used.
//
// Ports
//   clk                   rising-edge clock for all state
//   rst                   synchronous, active-high reset
//   fetch_pc_i            PC being fetched (combinational lookup)
//   fetch_compressed_i    fetched instruction is 16-bit (fall-through +2, else +4)
//   pred_dest_o           predicted next PC
//   pred_hit_o            lookup found a valid entry with a matching tag
//   update_valid_i        EX feedback valid
//   update_stall_i        EX stalled; feedback ignored this cycle
//   update_pc_i           PC of the resolved instruction
//   update_taken_i        branch was taken (ignored for jumps)
//   update_jump_i         resolved instruction is jal/jalr
//   update_target_i       resolved target address
//   update_mispredict_i   EX performed a PC correction
//   perf_update_cnt_o     effective-update count (wraps)
//   perf_mispredict_cnt_o effective updates that were mispredicts (wraps)
module branch_target_buffer #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc_i,
    input  logic        fetch_compressed_i,
    output logic [31:0] pred_dest_o,
    output logic        pred_hit_o,
    input  logic        update_valid_i,
    input  logic        update_stall_i,
    input  logic [31:0] update_pc_i,
    input  logic        update_taken_i,
    input  logic        update_jump_i,
    input  logic [31:0] update_target_i,
    input  logic        update_mispredict_i,
    output logic [31:0] perf_update_cnt_o,
    output logic [31:0] perf_mispredict_cnt_o
);

    localparam int unsigned TAG_W = 31 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [31:0] upd_cnt_q;
    logic [31:0] mispr_cnt_q;

    // Lookup
    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic [31:0]      fall_through;

    assign fetch_idx    = fetch_pc_i[IDX_W:1];
    assign fetch_tag    = fetch_pc_i[31:IDX_W+1];
    assign fall_through = fetch_pc_i + (fetch_compressed_i ? 32'd2 : 32'd4);
    assign pred_hit_o   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign pred_dest_o  = (pred_hit_o && ctr_q[fetch_idx][1]) ? target_q[fetch_idx]
                                                              : fall_through;

    // Update
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             upd_eff;
    logic             upd_taken;
    logic [1:0]       ctr_next;

    assign upd_idx   = update_pc_i[IDX_W:1];
    assign upd_tag   = update_pc_i[31:IDX_W+1];
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_eff   = update_valid_i && !update_stall_i;
    // A jump always counts as taken, whatever update_taken_i says.
    assign upd_taken = update_jump_i || update_taken_i;

    always_comb begin
        ctr_next = ctr_q[upd_idx];
        if (update_jump_i) begin
            ctr_next = 2'b11;
        end else if (update_taken_i) begin
            if (ctr_q[upd_idx] != 2'b11) ctr_next = ctr_q[upd_idx] + 2'b01;
        end else begin
            if (ctr_q[upd_idx] != 2'b00) ctr_next = ctr_q[upd_idx] - 2'b01;
        end
    end

    // Control state: valid bits, counters, perf counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '{default: 1'b0};
            ctr_q       <= '{default: 2'b01};
            upd_cnt_q   <= '0;
            mispr_cnt_q <= '0;
        end else if (upd_eff) begin
            upd_cnt_q <= upd_cnt_q + 32'd1;
            if (update_mispredict_i) mispr_cnt_q <= mispr_cnt_q + 32'd1;
            if (upd_hit) begin
                ctr_q[upd_idx] <= ctr_next;
            end else if (upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
                ctr_q[upd_idx]   <= update_jump_i ? 2'b11 : 2'b10;
            end
        end
    end

    // Payload (tag/target) carries no reset; it is only meaningful under valid.
    always_ff @(posedge clk) begin
        if (!rst && upd_eff && upd_taken) begin
            target_q[upd_idx] <= update_target_i;
            if (!upd_hit) tag_q[upd_idx] <= upd_tag;
        end
    end

    assign perf_update_cnt_o     = upd_cnt_q;
    assign perf_mispredict_cnt_o = mispr_cnt_q;

    logic unused_pc_lsb;
    assign unused_pc_lsb = fetch_pc_i[0] ^ update_pc_i[0];

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboarded bench for branch_target_buffer: each lookup pushes its expected
// hit/destination into a queue which the scenario task pops and compares.
module tb_branch_target_buffer;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc_i;
    logic        fetch_compressed_i;
    logic [31:0] pred_dest_o;
    logic        pred_hit_o;
    logic        update_valid_i;
    logic        update_stall_i;
    logic [31:0] update_pc_i;
    logic        update_taken_i;
    logic        update_jump_i;
    logic [31:0] update_target_i;
    logic        update_mispredict_i;
    logic [31:0] perf_update_cnt_o;
    logic [31:0] perf_mispredict_cnt_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct {
        logic        hit;
        logic [31:0] dest;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    branch_target_buffer #(.ENTRIES(16)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .fetch_pc_i            (fetch_pc_i),
        .fetch_compressed_i    (fetch_compressed_i),
        .pred_dest_o           (pred_dest_o),
        .pred_hit_o            (pred_hit_o),
        .update_valid_i        (update_valid_i),
        .update_stall_i        (update_stall_i),
        .update_pc_i           (update_pc_i),
        .update_taken_i        (update_taken_i),
        .update_jump_i         (update_jump_i),
        .update_target_i       (update_target_i),
        .update_mispredict_i   (update_mispredict_i),
        .perf_update_cnt_o     (perf_update_cnt_o),
        .perf_mispredict_cnt_o (perf_mispredict_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drives one effective (or stalled) update across a single clock edge.
    task automatic do_update(input logic [31:0] pc, input logic taken, input logic jump,
                             input logic [31:0] tgt, input logic mis, input logic stall);
        update_valid_i      = 1'b1;
        update_stall_i      = stall;
        update_pc_i         = pc;
        update_taken_i      = taken;
        update_jump_i       = jump;
        update_target_i     = tgt;
        update_mispredict_i = mis;
        @(posedge clk);
        #1;
        update_valid_i      = 1'b0;
        update_stall_i      = 1'b0;
        update_mispredict_i = 1'b0;
    endtask

    // Applies a fetch PC and queues the expected lookup result.
    task automatic fetch(input logic [31:0] pc, input logic comp,
                         input logic hit, input logic [31:0] dest);
        fetch_pc_i         = pc;
        fetch_compressed_i = comp;
        #1;
        exp_q.push_back('{hit: hit, dest: dest});
    endtask

    task automatic test_reset();
        do_reset();
        fetch(32'h100, 1'b0, 1'b0, 32'h104);
        e = exp_q.pop_front(); total++;
        if (pred_hit_o !== e.hit || pred_dest_o !== e.dest) begin bad++;
            $display("FAIL rst_fetch_100: hit=%0b dest=%h required hit=%0b dest=%h", pred_hit_o, pred_dest_o, e.hit, e.dest); end
        fetch(32'h100, 1'b1, 1'b0, 32'h102);
        e = exp_q.pop_front(); total++;
        if (pred_hit_o !== e.hit || pred_dest_o !== e.dest) begin bad++;
            $display("FAIL rst_fetch_100_c: hit=%0b dest=%h required hit=%0b dest=%h", pred_hit_o, pred_dest_o, e.hit, e.dest); end
        fetch(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        e = exp_q.pop_front(); total++;
        if (pred_hit_o !== e.hit || pred_dest_o !== e.dest) begin bad++;
            $display("FAIL rst_fetch_wrap: hit=%0b dest=%h required hit=%0b dest=%h", pred_hit_o, pred_dest_o, e.hit, e.dest); end
        total++;
        if (perf_update_cnt_o !== 32'd0 || perf_mispredict_cnt_o !== 32'd0) begin bad++;
            $display("FAIL rst_perf: upd=%h mis=%h required 0/0", perf_update_cnt_o, perf_mispredict_cnt_o); end
    endtask

    task automatic test_branch();
        // expected destination after each update at 0x100 (counter shown)
        logic [31:0] want [6];
        logic        tk   [6];
        want = '{32'h80, 32'h104, 32'h80, 32'h80, 32'h80, 32'h80};
        tk   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}; // 10,01,10,11,11,10
        for (int i = 0; i < 6; i++) begin
            do_update(32'h100, tk[i], 1'b0, 32'h80, 1'b0, 1'b0);
            fetch(32'h100, 1'b0, 1'b1, want[i]);
            e = exp_q.pop_front(); total++;
            if (pred_hit_o !== e.hit || pred_dest_o !== e.dest) begin bad++;
                $display("FAIL branch_step%0d: hit=%0b dest=%h required hit=%0b dest=%h", i, pred_hit_o, pred_dest_o, e.hit, e.dest); end
        end
    endtask

    task automatic test_jump();
        logic [31:0] want [6];
        logic        tk   [6];
        logic        jp   [6];
        logic [31:0] tg   [6];
        do_reset();
        // jump with taken=0 -> 11; NT x3 -> 10,01,00; taken -> 01; taken -> 10
        jp   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tk   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tg   = '{32'h400, 32'h0, 32'h0, 32'h0, 32'h600, 32'h600};
        want = '{32'h400, 32'h400, 32'h204, 32'h204, 32'h204, 32'h600};
        for (int i = 0; i < 6; i++) begin
            do_update(32'h200, tk[i], jp[i], tg[i], 1'b0, 1'b0);
            fetch(32'h200, 1'b0, 1'b1, want[i]);
            e = exp_q.pop_front(); total++;
            if (pred_hit_o !== e.hit || pred_dest_o !== e.dest) begin bad++;
                $display("FAIL jump_step%0d: hit=%0b dest=%h required hit=%0b dest=%h", i, pred_hit_o, pred_dest_o, e.hit, e.dest); end
            if (i == 3) begin
                total++;
                if (perf_update_cnt_o !== 32'd4) begin bad++;
                    $display("FAIL jump_perf: upd=%0d required 4", perf_update_cnt_o); end
            end
        end
    endtask

    task automatic test_stall_alias();
        do_reset();
        do_update(32'h100, 1'b1, 1'b0, 32'h80, 1'b1, 1'b1);
        fetch(32'h100, 1'b0, 1'b0, 32'h104);
        e = exp_q.pop_front(); total++;
        if (pred_hit_o !== e.hit || pred_dest_o !== e.dest) begin bad++;
            $display("FAIL stall_table: hit=%0b dest=%h required hit=%0b dest=%h", pred_hit_o, pred_dest_o, e.hit, e.dest); end
        total++;
        if (perf_update_cnt_o !== 32'd0 || perf_mispredict_cnt_o !== 32'd0) begin bad++;
            $display("FAIL stall_perf: upd=%h mis=%h required 0/0", perf_update_cnt_o, perf_mispredict_cnt_o); end
        do_update(32'h180, 1'b0, 1'b0, 32'h80, 1'b0, 1'b0);
        fetch(32'h180, 1'b0, 1'b0, 32'h184);
        e = exp_q.pop_front(); total++;
        if (pred_hit_o !== e.hit || pred_dest_o !== e.dest) begin bad++;
            $display("FAIL miss_nt: hit=%0b dest=%h required hit=%0b dest=%h", pred_hit_o, pred_dest_o, e.hit, e.dest); end
        do_update(32'h100, 1'b1, 1'b0, 32'h80, 1'b0, 1'b0);
        fetch(32'h100, 1'b0, 1'b1, 32'h80);
        e = exp_q.pop_front(); total++;
        if (pred_hit_o !== e.hit || pred_dest_o !== e.dest) begin bad++;
            $display("FAIL alias_alloc: hit=%0b dest=%h required hit=%0b dest=%h", pred_hit_o, pred_dest_o, e.hit, e.dest); end
        do_update(32'h140, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0);
        fetch(32'h100, 1'b0, 1'b0, 32'h104);
        e = exp_q.pop_front(); total++;
        if (pred_hit_o !== e.hit || pred_dest_o !== e.dest) begin bad++;
            $display("FAIL alias_evict: hit=%0b dest=%h required hit=%0b dest=%h", pred_hit_o, pred_dest_o, e.hit, e.dest); end
        fetch(32'h140, 1'b0, 1'b1, 32'h500);
        e = exp_q.pop_front(); total++;
        if (pred_hit_o !== e.hit || pred_dest_o !== e.dest) begin bad++;
            $display("FAIL alias_new: hit=%0b dest=%h required hit=%0b dest=%h", pred_hit_o, pred_dest_o, e.hit, e.dest); end
    endtask

    task automatic test_same_cycle();
        fetch_pc_i          = 32'h300;
        fetch_compressed_i  = 1'b0;
        update_valid_i      = 1'b1;
        update_stall_i      = 1'b0;
        update_pc_i         = 32'h300;
        update_taken_i      = 1'b0;
        update_jump_i       = 1'b1;
        update_target_i     = 32'h700;
        update_mispredict_i = 1'b0;
        #1;
        exp_q.push_back('{hit: 1'b0, dest: 32'h304});
        e = exp_q.pop_front(); total++;
        if (pred_hit_o !== e.hit || pred_dest_o !== e.dest) begin bad++;
            $display("FAIL same_cycle_pre: hit=%0b dest=%h required hit=%0b dest=%h", pred_hit_o, pred_dest_o, e.hit, e.dest); end
        @(posedge clk);
        #1;
        update_valid_i = 1'b0;
        exp_q.push_back('{hit: 1'b1, dest: 32'h700});
        e = exp_q.pop_front(); total++;
        if (pred_hit_o !== e.hit || pred_dest_o !== e.dest) begin bad++;
            $display("FAIL same_cycle_post: hit=%0b dest=%h required hit=%0b dest=%h", pred_hit_o, pred_dest_o, e.hit, e.dest); end
    endtask

    task automatic test_wrap();
        do_reset();
        dut.mispr_cnt_q = 32'hFFFF_FFFF;
        do_update(32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        total++;
        if (perf_mispredict_cnt_o !== 32'hFFFF_FFFF) begin bad++;
            $display("FAIL mis_no_inc: mis=%h required ffffffff", perf_mispredict_cnt_o); end
        do_update(32'h300, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        total++;
        if (perf_mispredict_cnt_o !== 32'h0 || perf_update_cnt_o !== 32'd2) begin bad++;
            $display("FAIL mis_wrap: mis=%h upd=%0d required 0/2", perf_mispredict_cnt_o, perf_update_cnt_o); end
    endtask

    task automatic test_mid_reset();
        do_update(32'h100, 1'b1, 1'b0, 32'h80, 1'b1, 1'b0);
        fetch(32'h100, 1'b0, 1'b1, 32'h80);
        e = exp_q.pop_front(); total++;
        if (pred_hit_o !== e.hit || pred_dest_o !== e.dest) begin bad++;
            $display("FAIL mid_pre: hit=%0b dest=%h required hit=%0b dest=%h", pred_hit_o, pred_dest_o, e.hit, e.dest); end
        rst = 1'b1;
        do_update(32'h140, 1'b0, 1'b1, 32'h500, 1'b1, 1'b0);
        rst = 1'b0;
        fetch(32'h100, 1'b0, 1'b0, 32'h104);
        e = exp_q.pop_front(); total++;
        if (pred_hit_o !== e.hit || pred_dest_o !== e.dest) begin bad++;
            $display("FAIL mid_100: hit=%0b dest=%h required hit=%0b dest=%h", pred_hit_o, pred_dest_o, e.hit, e.dest); end
        fetch(32'h140, 1'b1, 1'b0, 32'h142);
        e = exp_q.pop_front(); total++;
        if (pred_hit_o !== e.hit || pred_dest_o !== e.dest) begin bad++;
            $display("FAIL mid_140: hit=%0b dest=%h required hit=%0b dest=%h", pred_hit_o, pred_dest_o, e.hit, e.dest); end
        total++;
        if (perf_update_cnt_o !== 32'd0 || perf_mispredict_cnt_o !== 32'd0) begin bad++;
            $display("FAIL mid_perf: upd=%h mis=%h required 0/0", perf_update_cnt_o, perf_mispredict_cnt_o); end
    endtask

    initial begin
        rst                 = 1'b0;
        fetch_pc_i          = '0;
        fetch_compressed_i  = 1'b0;
        update_valid_i      = 1'b0;
        update_stall_i      = 1'b0;
        update_pc_i         = '0;
        update_taken_i      = 1'b0;
        update_jump_i       = 1'b0;
        update_target_i     = '0;
        update_mispredict_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_branch();
        test_jump();
        test_stall_alias();
        test_same_cycle();
        test_wrap();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
